// File: rtl/lane_judge_scheduler.sv
// Four-lane rhythm judge: walks chart rows, times key edges against each row's window and streams hit/miss events.
// Optional PERFECT_WINDOW_EN: hits in the middle half of the window score 2 and flag judge_perfect.
module lane_judge_scheduler #(
  parameter int ROW_W         = 8,
  parameter int LAST_ROW      = 255,
  parameter int TICKS_PER_ROW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       key,
  output logic [ROW_W-1:0] rom_addr,
  input  logic [3:0]       rom_data,
  output logic [15:0]      score,
  output logic [11:0]      combo,
  output logic [11:0]      max_combo,
  output logic             judge_valid,
  input  logic             judge_ready,
  output logic [1:0]       judge_lane,
  output logic             judge_hit,
  output logic             judge_perfect,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DRAIN, FIN} state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row;
  logic [15:0]      tick;
  logic [3:0]       pending, key_prev, flag, evt_hit, evt_perf;
  logic [1:0]       ptr, lane_sel;
  logic             valid_q;

  logic [3:0]  key_edge, hit, miss, perf, raise, clr, flag_nxt;
  logic        last_tick, row_last, accept, can_load, found;
  logic [1:0]  gnt;
  logic [3:0]  hit_pts;
  logic [11:0] combo_base, combo_nxt;
  logic [15:0] score_nxt;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [11:0] sat12(input logic [12:0] v);
    return v[12] ? 12'hFFF : v[11:0];
  endfunction

  assign last_tick = (tick == 16'(TICKS_PER_ROW - 1));
  assign row_last  = (row == ROW_W'(LAST_ROW));
  assign key_edge  = key & ~key_prev;
  assign hit       = (state == PLAY) ? (key_edge & pending) : 4'b0;
  // A key edge on the final tick wins over the timeout miss.
  assign miss      = (state == PLAY && last_tick) ? (pending & ~key_edge) : 4'b0;
  assign raise     = hit | miss;

`ifdef PERFECT_WINDOW_EN
  assign perf = (tick >= 16'(TICKS_PER_ROW / 4) && tick < 16'((3 * TICKS_PER_ROW) / 4)) ? hit : 4'b0;
`else
  assign perf = 4'b0;
`endif

  assign hit_pts    = {1'b0, popcnt4(hit)} + {1'b0, popcnt4(perf)};
  assign score_nxt  = sat16({1'b0, score} + 17'(hit_pts));
  assign combo_base = (|miss) ? 12'd0 : combo;
  assign combo_nxt  = sat12({1'b0, combo_base} + 13'(popcnt4(hit)));

  assign accept   = valid_q & judge_ready;
  assign clr      = accept ? (4'b0001 << lane_sel) : 4'b0;
  assign flag_nxt = (flag & ~clr) | raise;
  assign can_load = ~valid_q | judge_ready;

  // Round-robin pick starting at ptr; the presented lane is held until accepted.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    gnt   = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && flag_nxt[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign judge_valid   = valid_q;
  assign judge_lane    = lane_sel;
  assign judge_hit     = evt_hit[lane_sel];
  assign judge_perfect = evt_perf[lane_sel];
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = PLAY;
      PLAY:    if (last_tick) state_nxt = DRAIN;
      DRAIN:   if (flag == 4'b0) state_nxt = row_last ? FIN : FETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr  <= '0;
      row       <= '0;
      tick      <= '0;
      pending   <= '0;
      key_prev  <= '0;
      flag      <= '0;
      evt_hit   <= '0;
      evt_perf  <= '0;
      ptr       <= '0;
      lane_sel  <= '0;
      valid_q   <= 1'b0;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else begin
      key_prev <= key;
      flag     <= flag_nxt;
      evt_hit  <= (evt_hit & ~raise) | hit;
      evt_perf <= (evt_perf & ~raise) | perf;
      if (can_load) begin
        valid_q <= found;
        if (found) begin
          lane_sel <= gnt;
          ptr      <= gnt + 2'd1;
        end
      end
      case (state)
        IDLE: if (start) begin
          score     <= '0;
          combo     <= '0;
          max_combo <= '0;
          row       <= '0;
          rom_addr  <= '0;
        end
        LOAD: begin
          pending <= rom_data;
          tick    <= '0;
        end
        PLAY: begin
          tick    <= tick + 16'd1;
          pending <= pending & ~raise;
          if (|raise) begin
            score     <= score_nxt;
            combo     <= combo_nxt;
            max_combo <= (combo_nxt > max_combo) ? combo_nxt : max_combo;
          end
        end
        DRAIN: if (flag == 4'b0 && !row_last) begin
          row      <= row + ROW_W'(1);
          rom_addr <= row + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_judge_scheduler.sv
// Directed bench for lane_judge_scheduler: four-row chart, hit/miss/backpressure/reset scenarios, second play to done.
module tb_lane_judge_scheduler;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst, start, judge_ready;
  logic [3:0]  key, rom_data;
  logic [7:0]  rom_addr;
  logic [15:0] score;
  logic [11:0] combo, max_combo;
  logic        judge_valid, judge_hit, judge_perfect, busy, done;
  logic [1:0]  judge_lane;
  logic [3:0]  mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;
  int exp_score = 0;

  lane_judge_scheduler #(.ROW_W(8), .LAST_ROW(3), .TICKS_PER_ROW(T)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .score(score), .combo(combo), .max_combo(max_combo),
    .judge_valid(judge_valid), .judge_ready(judge_ready),
    .judge_lane(judge_lane), .judge_hit(judge_hit), .judge_perfect(judge_perfect),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hv(input int t);
`ifdef PERFECT_WINDOW_EN
    return (t >= T / 4 && t < (3 * T) / 4) ? 2 : 1;
`else
    return (t >= 0) ? 1 : 1;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Tick k of the current row is the negedge k+2 after the FETCH negedge.
  task automatic go_tick(input int k);
    step(k - cur);
    cur = k;
  endtask

  task automatic wait_fetch(input logic [7:0] r);
    for (int i = 0; i < 200 && rom_addr !== r; i++) @(negedge clk);
    check("wait_row", rom_addr, r);
    cur = -2;
  endtask

  task automatic check_evt(input string tag, input int lane, input int hit, input int perf);
    check({tag, "_valid"}, judge_valid, 1);
    check({tag, "_lane"}, judge_lane, lane);
    check({tag, "_hit"}, judge_hit, hit);
    check({tag, "_perf"}, judge_perfect, perf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    for (int i = 0; i < 256; i++) mem[i] = 4'b0000;
    mem[0] = 4'b0001;
    mem[1] = 4'b1111;
    mem[2] = 4'b0011;
    rst = 1'b1; start = 1'b0; key = 4'b0; judge_ready = 1'b1;
    step(2);
    check("rst_addr", rom_addr, 0);
    check("rst_score", score, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", judge_valid, 0);
    rst = 1'b0;
    step(1);

    // Play 1, row 0: single note on lane 0 hit at tick 2
    start = 1'b1;
    step(1);
    start = 1'b0;
    cur = -2;
    check("p1_busy", busy, 1);
    check("p1_addr0", rom_addr, 0);
    go_tick(2); key = 4'b0001;
    go_tick(3); key = 4'b0000;
    exp_score += hv(2);
    check_evt("r0", 0, 1, hv(2) == 2);
    check("r0_score", score, exp_score);
    check("r0_combo", combo, 1);

    // Row 1: four simultaneous hits, pointer now at lane 1
    wait_fetch(1);
    go_tick(3); key = 4'b1111;
    go_tick(4); key = 4'b0000;
    exp_score += 4 * hv(3);
    check_evt("r1a", 1, 1, hv(3) == 2);
    check("r1_score", score, exp_score);
    check("r1_combo", combo, 5);
    check("r1_max", max_combo, 5);
    go_tick(5); check_evt("r1b", 2, 1, hv(3) == 2);
    go_tick(6); check_evt("r1c", 3, 1, hv(3) == 2);
    go_tick(7); check_evt("r1d", 0, 1, hv(3) == 2);
    go_tick(8); check("r1_idle_valid", judge_valid, 0);

    // Row 2: lane 0 hit, lane 1 times out; then backpressure in DRAIN
    wait_fetch(2);
    go_tick(5); key = 4'b0001;
    go_tick(6); key = 4'b0000;
    exp_score += hv(5);
    check_evt("r2hit", 0, 1, hv(5) == 2);
    check("r2_combo6", combo, 6);
    go_tick(10); judge_ready = 1'b0;
    go_tick(16);
    check_evt("r2miss", 1, 0, 0);
    check("r2_combo0", combo, 0);
    check("r2_max", max_combo, 6);
    check("r2_score", score, exp_score);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("hold_valid", judge_valid, 1);
      check("hold_lane", judge_lane, 1);
    end
    check("hold_hit", judge_hit, 0);
    check("hold_addr", rom_addr, 2);
    check("hold_busy", busy, 1);
    judge_ready = 1'b1;

    // Row 3: asynchronous reset mid-play
    wait_fetch(3);
    go_tick(4); rst = 1'b1;
    step(1);
    check("ab_addr", rom_addr, 0);
    check("ab_score", score, 0);
    check("ab_combo", combo, 0);
    check("ab_max", max_combo, 0);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_valid", judge_valid, 0);
    rst = 1'b0;

    // Play 2: fresh arbiter pointer, four hits in lane order, then run to done
    mem[0] = 4'b1111; mem[1] = 4'b0000; mem[2] = 4'b0000;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    cur = -2;
    check("p2_busy", busy, 1);
    check("p2_addr0", rom_addr, 0);
    go_tick(3); key = 4'b1111;
    go_tick(4); key = 4'b0000;
    exp_score = 4 * hv(3);
    check_evt("p2a", 0, 1, hv(3) == 2);
    go_tick(5); check_evt("p2b", 1, 1, hv(3) == 2);
    go_tick(6); check_evt("p2c", 2, 1, hv(3) == 2);
    go_tick(7); check_evt("p2d", 3, 1, hv(3) == 2);
    check("p2_score", score, exp_score);
    check("p2_combo", combo, 4);

    wait_fetch(1);
    go_tick(2); key = 4'b0100;
    go_tick(3); key = 4'b0000;
    check("nonote_valid", judge_valid, 0);
    check("nonote_score", score, exp_score);
    check("nonote_combo", combo, 4);

    done_cnt = 0;
    for (int i = 0; i < 200 && done !== 1'b1; i++) step(1);
    check("done_seen", done, 1);
    while (done === 1'b1 && done_cnt < 5) begin
      done_cnt++;
      step(1);
    end
    check("done_width", done_cnt, 1);
    check("end_busy", busy, 0);
    check("end_addr", rom_addr, 3);
    check("end_max", max_combo, 4);
    check("end_score", score, exp_score);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
